// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : act_pkg
//  Description : Shared types and helpers for the activation stream block:
//                activation mode encoding, statistic width default and the
//                zero-lane population count.
//  Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

    // Run-time activation selection, encoded exactly as the cfg_mode field
    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_CLIP   = 2'b11
    } act_mode_e;

    // Default width of the per-frame zero-count accumulator
    localparam int STAT_W_DEFAULT = 32;

    // Widest lane-flag vector the popcount helper accepts; narrower vectors
    // are zero-extended by the caller so unused bits never count.
    localparam int MAX_LANES = 64;

    // Number of set bits in a vector of per-lane "result is zero" flags
    function automatic int unsigned popcount_zero(input logic [MAX_LANES-1:0] zero_flags);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            cnt = cnt + {31'b0, zero_flags[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// ============================================================================
//  Module      : act_lane
//  Description : Combinational single-element activation. Selects between
//                bypass, ReLU, leaky ReLU (arithmetic shift) and clipped ReLU
//                and flags a zero result for the sparsity statistic.
//  Revision    : 1.0 - initial release
// ============================================================================
module act_lane
    import act_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic signed [BITWIDTH-1:0] x,
    input  logic        [1:0]          mode,
    input  logic        [4:0]          shift,
    input  logic signed [BITWIDTH-1:0] clip_max,
    output logic signed [BITWIDTH-1:0] y,
    output logic                       is_zero
);

    // Shift amounts at or beyond the element width saturate a negative input
    // to -1, which is what an unbounded arithmetic shift would converge to.
    localparam logic [31:0] c_width = BITWIDTH;

    logic w_neg;
    assign w_neg = x[BITWIDTH-1];

    // Per-element activation; result never widens beyond BITWIDTH
    always_comb begin
        y = x;
        case (act_mode_e'(mode))
            ACT_BYPASS: y = x;
            ACT_RELU: begin
                if (w_neg) y = '0;
            end
            ACT_LEAKY: begin
                if (w_neg) begin
                    if (32'(shift) >= c_width) y = '1;
                    else                       y = x >>> shift;
                end
            end
            ACT_CLIP: begin
                // A negative ceiling forces every output to zero
                if (clip_max[BITWIDTH-1] || w_neg) y = '0;
                else if (x > clip_max)             y = clip_max;
            end
            default: y = x;
        endcase
        is_zero = (y == '0);
    end

endmodule
`default_nettype wire

// File: rtl/activation_stream.sv
`default_nettype none
// ============================================================================
//  Module      : activation_stream
//  Description : Two-stage pipelined activation over LANES signed elements per
//                beat with valid/ready backpressure and a per-frame count of
//                zero elements emitted. Configuration is captured with each
//                beat so mid-stream changes only affect later beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module activation_stream
    import act_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int LANES    = 10,
    parameter int STAT_W   = STAT_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic        [1:0]          cfg_mode,
    input  logic        [4:0]          cfg_leak_shift,
    input  logic signed [BITWIDTH-1:0] cfg_clip_max,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data [LANES-1:0],
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITWIDTH-1:0] out_data [LANES-1:0],
    output logic                       out_last,
    output logic                       stat_valid,
    output logic        [STAT_W-1:0]   stat_zeros
);

    localparam int PC_W = $clog2(LANES + 1);

    // Stage 1: captured beat plus the configuration it must be processed with
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic signed [BITWIDTH-1:0] r_s1_data [LANES-1:0];
    logic        [1:0]          r_s1_mode;
    logic        [4:0]          r_s1_shift;
    logic signed [BITWIDTH-1:0] r_s1_clip;

    // Stage 2: activated result lives directly in out_data/out_last
    logic                       r_s2_valid;
    logic        [PC_W-1:0]     r_s2_pc;

    // Running zero count of the frame in progress
    logic        [STAT_W-1:0]   r_acc;

    logic                       w_adv1;
    logic                       w_adv2;
    logic                       w_out_fire;
    logic signed [BITWIDTH-1:0] w_act [LANES-1:0];
    logic        [LANES-1:0]    w_zero;
    logic        [MAX_LANES-1:0] w_zero_pad;
    logic        [PC_W-1:0]     w_pc;
    logic        [STAT_W:0]     w_sum;
    logic        [STAT_W-1:0]   w_sum_sat;

    // A stage may advance when it is empty or its successor is advancing
    assign w_adv2     = !r_s2_valid || out_ready;
    assign w_adv1     = !r_s1_valid || w_adv2;
    assign in_ready   = w_adv1;
    assign out_valid  = r_s2_valid;
    assign w_out_fire = r_s2_valid && out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lanes
        act_lane #(
            .BITWIDTH (BITWIDTH)
        ) u_lane (
            .x        (r_s1_data[g]),
            .mode     (r_s1_mode),
            .shift    (r_s1_shift),
            .clip_max (r_s1_clip),
            .y        (w_act[g]),
            .is_zero  (w_zero[g])
        );
    end

    assign w_zero_pad = MAX_LANES'(w_zero);
    assign w_pc       = PC_W'(popcount_zero(w_zero_pad));

    // One extra bit catches accumulator overflow so it can saturate
    assign w_sum     = {1'b0, r_acc} + (STAT_W + 1)'(r_s2_pc);
    assign w_sum_sat = w_sum[STAT_W] ? {STAT_W{1'b1}} : w_sum[STAT_W-1:0];

    // Stage 1 capture of data, last flag and per-beat configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_shift <= 5'd0;
            r_s1_clip  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_data[i] <= '0;
            end
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_last  <= in_last;
                r_s1_mode  <= cfg_mode;
                r_s1_shift <= cfg_leak_shift;
                r_s1_clip  <= cfg_clip_max;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_data[i] <= in_data[i];
                end
            end
        end
    end

    // Stage 2 holds the activated beat and its zero count; frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            out_last   <= 1'b0;
            r_s2_pc    <= '0;
            for (int i = 0; i < LANES; i++) begin
                out_data[i] <= '0;
            end
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_last <= r_s1_last;
                r_s2_pc  <= w_pc;
                for (int i = 0; i < LANES; i++) begin
                    out_data[i] <= w_act[i];
                end
            end
        end
    end

    // Frame zero-count accumulation and one-cycle completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            stat_zeros <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (w_out_fire) begin
                if (out_last) begin
                    stat_zeros <= w_sum_sat;
                    stat_valid <= 1'b1;
                    r_acc      <= '0;
                end else begin
                    r_acc <= w_sum_sat;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/activation_stream.md
Name: activation_stream

Overview:
- Parametrised, pipelined successor to the combinational per-layer ReLU blocks.
- Applies a run-time-selectable activation to LANES signed fixed-point elements per beat. Modes: bypass, ReLU, leaky ReLU, clipped ReLU.
- Uses a valid/ready stream with backpressure and a per-frame sparsity (zero-count) statistic.
- Sits between a conv/FC accumulator output and the next layer's input buffer.

Parameters:
BITWIDTH, 32, element width, two's complement
LANES, 10, elements per beat
STAT_W, 32, width of zero-count accumulator

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_mode  input  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
cfg_leak_shift  input  5  leaky slope = 2^-shift
cfg_clip_max  input  BITWIDTH  signed clip ceiling for mode 11
in_valid  input  1  input beat valid
in_ready  output  1  block can accept beat
in_data  input  BITWIDTH x LANES  unpacked array [LANES-1:0]
in_last  input  1  final beat of frame
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  BITWIDTH x LANES  activated elements
out_last  output  1  in_last delayed with its beat
stat_valid  output  1  one-cycle pulse, frame statistic ready
stat_zeros  output  STAT_W  zero elements emitted in the completed frame

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_data 0, out_last 0, stat_valid 0, stat_zeros 0, accumulator 0.
- Two register stages, S1 and S2. Latency is 2 cycles from acceptance to out_valid with no stall.
  - S1 captures in_data, in_last, cfg_mode, cfg_leak_shift and cfg_clip_max on acceptance. Config is therefore per-beat; a mid-stream config change affects only later beats.
  - S2 holds the activated result and per-beat zero popcount.
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - Acceptance occurs when in_valid && in_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable. No beat is lost or duplicated, and full throughput (1 beat/cycle) is sustained while out_ready = 1.
- Per-element function, x signed:
  - bypass: y = x.
  - ReLU: y = (x < 0) ? 0 : x.
  - leaky: y = (x < 0) ? (x >>> shift) : x. The shift is arithmetic. shift = 0 gives y = x. shift ≥ BITWIDTH gives -1 for negative x.
  - clipped: y = (x < 0) ? 0 : (x > clip_max ? clip_max : x), compared signed. If clip_max < 0, y = 0 for all x.
  - Outputs never exceed BITWIDTH; no widening.
- Statistic:
  - On each output handshake (out_valid && out_ready), let pc = number of lanes with y == 0.
  - Non-last beat: acc += pc, saturating at 2^STAT_W-1.
  - Last beat: stat_zeros <= sat(acc + pc), stat_valid pulses 1 cycle later, and acc <= 0.
  - stat_zeros holds until the next frame completes.
  - A single-beat frame (in_last on first beat) reports pc only.
- Reset mid-frame discards in-flight beats and the accumulator; no stat_valid results.

Decomposition:
- Package act_pkg holds:
  - the mode enum act_mode_e (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP)
  - the STAT_W default
  - function popcount_zero
- One sub-module, act_lane: a combinational single-element function (x, mode, shift, clip_max → y, is_zero), instantiated LANES times with generate.
- The top holds the pipeline registers, the handshake and the statistic.

Test Plan:
- ReLU mode, LANES=10, beat {-5, 0, 7, -1, 2^31-1, -2^31, 3, -3, 1, -100}, out_ready=1 → after 2 cycles out_data {0, 0, 7, 0, 2^31-1, 0, 3, 0, 1, 0}.
- Leaky, shift=2, x=-8 → -2; x=-1 → -1; x=-2^31 → -2^29; x=12 → 12. Also mode switched to bypass on the next beat → that beat passes unchanged while the prior beat still uses leaky.
- Clipped, clip_max=100: x=150 → 100, x=-4 → 0, x=100 → 100. Then clip_max=-1: all outputs 0.
- Backpressure: stream 6 beats back-to-back with out_ready toggling 1,0,0,1,…
  - Output order, data and last are preserved.
  - in_ready drops only when both stages are full.
  - out_data is stable while stalled.
- Statistic: 3-beat frame in ReLU with zero counts 4, 6, 10, last on beat 3 → stat_valid pulses once with stat_zeros=20. The next 1-beat frame with 2 zeros → stat_zeros=2.
- Assert rst mid-frame with both stages valid → out_valid and stat_valid are 0 immediately. A following 1-beat frame with 5 zeros reports stat_zeros=5.
